// File: rtl/onoc_arb_pkg.sv
// Shared definitions for the optical-channel arbiters.
//
// Contents:
//   arb_state_t - arbitration FSM state
//                 IDLE:       no grant outstanding, channel free
//                 GRANT_WAIT: grant issued, waiting for the grantee to accept
//                 BUSY:       grantee holds the channel until done or eviction
package onoc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_WAIT = 2'd1,
        BUSY       = 2'd2
    } arb_state_t;

endpackage : onoc_arb_pkg

// File: rtl/rr_channel_arbiter_pick.sv
// rr_pick: combinational rotate-priority encoder.
//
// Returns the first set request bit found when scanning upward from ptr,
// wrapping from NUM_ROUTERS-1 back to 0.
//
// Ports:
//   request [NUM_ROUTERS-1:0]         in  request vector
//   ptr     [$clog2(NUM_ROUTERS)-1:0] in  scan start position (< NUM_ROUTERS)
//   valid                             out at least one request bit is set
//   index   [$clog2(NUM_ROUTERS)-1:0] out winning router index (0 when !valid)
module rr_pick #(
    parameter int NUM_ROUTERS = 4,
    localparam int PW = $clog2(NUM_ROUTERS)
) (
    input  logic [NUM_ROUTERS-1:0] request,
    input  logic [PW-1:0]          ptr,
    output logic                   valid,
    output logic [PW-1:0]          index
);

    int          pos;
    logic [PW-1:0] idx;

    // NOTE: every variable written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        valid = 1'b0;
        index = '0;
        pos   = 0;
        idx   = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            // Modulo by subtraction: ptr < N and i < N, so one wrap suffices.
            pos = int'(ptr) + i;
            if (pos >= NUM_ROUTERS) pos = pos - NUM_ROUTERS;
            idx = PW'(pos);
            if (!valid && request[idx]) begin
                valid = 1'b1;
                index = idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_channel_arbiter.sv
// rr_channel_arbiter: round-robin owner selection for one shared optical
// channel. A winner is granted, must accept within GRANT_TIMEOUT cycles, then
// holds the channel until it signals done or MAX_HOLD cycles elapse. Every
// ownership ends by moving the round-robin pointer past the last owner.
//
// Ports:
//   clk                 in  rising-edge clock
//   rst                 in  synchronous active-high reset
//   request [N-1:0]     in  per-router level request
//   accept  [N-1:0]     in  per-router grant acknowledgement (owner bit only)
//   done    [N-1:0]     in  per-router transmission complete (owner bit only)
//   grant   [N-1:0]     out registered one-hot grant, or zero
//   owner   [log2N-1:0] out current grantee/holder, 0 when idle
//   channel_busy        out channel held
//   grant_timeout       out one-cycle pulse: grant expired unaccepted
//   hold_overrun        out one-cycle pulse: holder evicted
module rr_channel_arbiter
    import onoc_arb_pkg::*;
#(
    parameter int NUM_ROUTERS   = 4,
    parameter int GRANT_TIMEOUT = 8,
    parameter int MAX_HOLD      = 64,
    localparam int PW = $clog2(NUM_ROUTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_ROUTERS-1:0] request,
    input  logic [NUM_ROUTERS-1:0] accept,
    input  logic [NUM_ROUTERS-1:0] done,
    output logic [NUM_ROUTERS-1:0] grant,
    output logic [PW-1:0]          owner,
    output logic                   channel_busy,
    output logic                   grant_timeout,
    output logic                   hold_overrun
);

    localparam int WCW = $clog2(GRANT_TIMEOUT);
    localparam int HCW = $clog2(MAX_HOLD);
    localparam logic [PW-1:0]  LAST_IDX  = PW'(NUM_ROUTERS - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(GRANT_TIMEOUT - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    arb_state_t             state, state_n;
    logic [PW-1:0]          ptr, ptr_n;
    logic [WCW-1:0]         wait_cnt, wait_cnt_n;
    logic [HCW-1:0]         hold_cnt, hold_cnt_n;
    logic [NUM_ROUTERS-1:0] grant_n;
    logic [PW-1:0]          owner_n;
    logic                   busy_n, timeout_n, overrun_n;

    logic                   pick_valid;
    logic [PW-1:0]          pick_index;
    logic [PW-1:0]          ptr_after_owner;

    rr_pick #(.NUM_ROUTERS(NUM_ROUTERS)) u_pick (
        .request (request),
        .ptr     (ptr),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    // Explicit wrap so non-power-of-two router counts stay in range.
    assign ptr_after_owner = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        wait_cnt_n = wait_cnt;
        hold_cnt_n = hold_cnt;
        grant_n    = grant;
        owner_n    = owner;
        busy_n     = channel_busy;
        timeout_n  = 1'b0;
        overrun_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_n             = '0;
                    grant_n[pick_index] = 1'b1;
                    owner_n             = pick_index;
                    wait_cnt_n          = '0;
                    state_n             = GRANT_WAIT;
                end
            end

            GRANT_WAIT: begin
                // Accept wins over both withdrawal and expiry.
                if (accept[owner]) begin
                    grant_n    = '0;
                    busy_n     = 1'b1;
                    hold_cnt_n = '0;
                    state_n    = BUSY;
                end else if (!request[owner] || wait_cnt == WAIT_LAST) begin
                    // A withdrawn request ends quietly even on the expiry cycle.
                    timeout_n = request[owner];
                    grant_n   = '0;
                    owner_n   = '0;
                    ptr_n     = ptr_after_owner;
                    state_n   = IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            BUSY: begin
                if (done[owner] || hold_cnt == HOLD_LAST) begin
                    overrun_n = !done[owner];
                    busy_n    = 1'b0;
                    owner_n   = '0;
                    ptr_n     = ptr_after_owner;
                    state_n   = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            default: begin
                grant_n = '0;
                owner_n = '0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            wait_cnt      <= '0;
            hold_cnt      <= '0;
            grant         <= '0;
            owner         <= '0;
            channel_busy  <= 1'b0;
            grant_timeout <= 1'b0;
            hold_overrun  <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            wait_cnt      <= wait_cnt_n;
            hold_cnt      <= hold_cnt_n;
            grant         <= grant_n;
            owner         <= owner_n;
            channel_busy  <= busy_n;
            grant_timeout <= timeout_n;
            hold_overrun  <= overrun_n;
        end
    end

endmodule : rr_channel_arbiter

// File: tb/tb_rr_channel_arbiter.sv
// Directed bench for rr_channel_arbiter (N=4, GRANT_TIMEOUT=8, MAX_HOLD=64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_channel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] request, accept, done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       channel_busy, grant_timeout, hold_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    rr_channel_arbiter #(
        .NUM_ROUTERS   (4),
        .GRANT_TIMEOUT (8),
        .MAX_HOLD      (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .accept        (accept),
        .done          (done),
        .grant         (grant),
        .owner         (owner),
        .channel_busy  (channel_busy),
        .grant_timeout (grant_timeout),
        .hold_overrun  (hold_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"},   32'(grant),         32'h0);
        check({tag, ".owner"},   32'(owner),         32'h0);
        check({tag, ".busy"},    32'(channel_busy),  32'h0);
        check({tag, ".timeout"}, 32'(grant_timeout), 32'h0);
        check({tag, ".overrun"}, 32'(hold_overrun),  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] s1_grant [5];
        logic [3:0] one_hot;
        s1_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst = 1'b1; request = '0; accept = '0; done = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Scenario 1: all request; accept, done 3 cycles into BUSY, rotate.
        request = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            check($sformatf("s1.grant%0d", r), 32'(grant), 32'(s1_grant[r]));
            check($sformatf("s1.owner%0d", r), 32'(owner), 32'(r % 4));
            one_hot = s1_grant[r];
            accept = one_hot;
            tick();
            accept = '0;
            check($sformatf("s1.busy%0d", r), 32'(channel_busy), 32'h1);
            check($sformatf("s1.gclr%0d", r), 32'(grant), 32'h0);
            tick(); tick();
            done = one_hot;
            if (r == 4) request = '0;
            tick();
            done = '0;
            // Mandatory idle cycle between ownerships.
            check($sformatf("s1.idle_busy%0d", r), 32'(channel_busy), 32'h0);
            check($sformatf("s1.idle_grant%0d", r), 32'(grant), 32'h0);
            tick();
        end
        // ptr = 1 now, state IDLE, nothing requested.
        check("s1.quiet", 32'(grant), 32'h0);

        // Scenario 2: router 2 never accepts -> 8 grant cycles then timeout.
        request = 4'b0100;
        tick();
        check("s2.owner", 32'(owner), 32'h2);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) tick();
            check($sformatf("s2.grant_c%0d", c), 32'(grant), 32'h4);
            check($sformatf("s2.nopulse_c%0d", c), 32'(grant_timeout), 32'h0);
        end
        tick();
        check("s2.expire_grant", 32'(grant), 32'h0);
        check("s2.expire_pulse", 32'(grant_timeout), 32'h1);
        tick();
        check("s2.regrant", 32'(grant), 32'h4);
        check("s2.pulse_once", 32'(grant_timeout), 32'h0);
        // Withdraw: grant drops, no pulse, ptr -> 3.
        request = '0;
        tick();
        check("s2.withdraw_grant", 32'(grant), 32'h0);
        check("s2.withdraw_nopulse", 32'(grant_timeout), 32'h0);

        // Scenario 3: from ptr 3, router 1 wins; foreign accept ignored;
        // owner accept on the expiry cycle wins over timeout.
        request = 4'b0010;
        tick();
        check("s3.grant", 32'(grant), 32'h2);
        check("s3.owner", 32'(owner), 32'h1);
        accept = 4'b0100;
        tick();
        accept = '0;
        check("s3.foreign_grant", 32'(grant), 32'h2);
        check("s3.foreign_busy", 32'(channel_busy), 32'h0);
        repeat (6) tick();
        check("s3.last_wait_grant", 32'(grant), 32'h2);
        accept = 4'b0010;
        tick();
        accept = '0;
        check("s3.busy", 32'(channel_busy), 32'h1);
        check("s3.grant_clr", 32'(grant), 32'h0);
        check("s3.no_timeout", 32'(grant_timeout), 32'h0);
        request = '0;
        done = 4'b0010;
        tick();
        done = '0;
        check("s3.done_busy", 32'(channel_busy), 32'h0);
        check("s3.no_overrun", 32'(hold_overrun), 32'h0);

        // Scenario 4: from ptr 2, router 3 holds without done -> overrun.
        request = 4'b1000;
        tick();
        check("s4.grant", 32'(grant), 32'h8);
        check("s4.owner", 32'(owner), 32'h3);
        accept = 4'b1000;
        tick();
        accept = '0;
        done = 4'b0001;  // foreign done must be ignored
        tick();
        done = '0;
        check("s4.foreign_done", 32'(channel_busy), 32'h1);
        for (int c = 2; c < 64; c++) begin
            tick();
            check($sformatf("s4.busy_c%0d", c), 32'(channel_busy), 32'h1);
            check($sformatf("s4.nopulse_c%0d", c), 32'(hold_overrun), 32'h0);
        end
        request = 4'b1001;
        tick();
        check("s4.evict_busy", 32'(channel_busy), 32'h0);
        check("s4.evict_pulse", 32'(hold_overrun), 32'h1);
        check("s4.evict_owner", 32'(owner), 32'h0);
        tick();
        // ptr wrapped to 0: router 0 beats router 3.
        check("s4.ptr0_grant", 32'(grant), 32'h1);
        check("s4.pulse_once", 32'(hold_overrun), 32'h0);

        // Move ptr to 2 via two withdrawals, then hold with router 2.
        request = 4'b0010;
        tick();
        check("s5.wd0", 32'(grant), 32'h0);
        tick();
        check("s5.g1", 32'(grant), 32'h2);
        request = 4'b0100;
        tick();
        check("s5.wd1", 32'(grant), 32'h0);
        tick();
        check("s5.g2", 32'(grant), 32'h4);
        accept = 4'b0100;
        tick();
        accept = '0;
        check("s5.busy", 32'(channel_busy), 32'h1);
        tick();

        // Scenario 5: reset mid-BUSY, then first grant chosen from ptr 0.
        rst = 1'b1;
        request = 4'b1010;
        tick();
        check_all_zero("s5.rst");
        rst = 1'b0;
        tick();
        check("s5.first_grant", 32'(grant), 32'h2);
        check("s5.first_owner", 32'(owner), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rr_channel_arbiter
